// File: rtl/ara_pkg.sv
// Shared types and helpers for the vector alignment stage: element widths, cluster
// metadata and AXI page arithmetic.
package ara_pkg;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  typedef logic [15:0] vlen_cluster_t;

  typedef struct packed {
    vlen_cluster_t vl;
    vew_e          vew;
  } cluster_metadata_t;

  localparam int unsigned AxiPageBytes = 4096;
  localparam logic [1:0]  AxiBurstIncr = 2'b01;

  // Beats from the beat containing page_off up to the end of the 4 KiB page; never 0.
  function automatic logic [12:0] beats_to_page(logic [11:0] page_off, int unsigned beat_shift);
    logic [12:0] aligned;
    aligned = {1'b0, page_off} & ~((13'd1 << beat_shift) - 13'd1);
    return (13'(AxiPageBytes) - aligned) >> beat_shift;
  endfunction

endpackage

// File: rtl/align_burst_calc.sv
// Combinational burst sizing: length of the burst at cur_addr and the address of the
// burst that follows it.
module align_burst_calc
  import ara_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned BeatsWidth   = 20,
  parameter int unsigned BeatShift    = 6,
  parameter int unsigned MaxBurstLen  = 16
) (
  input  logic [AxiAddrWidth-1:0] cur_addr_i,
  input  logic [BeatsWidth-1:0]   beats_left_i,
  output logic [8:0]              cur_len_o,
  output logic [AxiAddrWidth-1:0] next_addr_o
);

  logic [31:0]             page_beats;
  logic [31:0]             limit;
  logic [8:0]              len;
  logic [AxiAddrWidth-1:0] aligned_addr;

  always_comb begin
    page_beats   = 32'(beats_to_page(cur_addr_i[11:0], BeatShift));
    limit        = (page_beats < MaxBurstLen) ? page_beats : MaxBurstLen;
    len          = 9'((32'(beats_left_i) < limit) ? 32'(beats_left_i) : limit);
    aligned_addr = cur_addr_i & ~((AxiAddrWidth'(1) << BeatShift) - AxiAddrWidth'(1));
    cur_len_o    = len;
    next_addr_o  = aligned_addr + (AxiAddrWidth'(len) << BeatShift);
  end

endmodule

// File: rtl/align_req_sequencer.sv
// Splits a vector memory descriptor into AXI4 INCR bursts on AR or AW, holding the
// cluster metadata stable until the final burst is accepted.
module align_req_sequencer
  import ara_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 512,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned VlWidth      = 16,
  parameter int unsigned MaxBurstLen  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AxiAddrWidth-1:0] req_addr_i,
  input  logic [VlWidth-1:0]      req_vl_i,
  input  vew_e                    req_vew_i,
  input  logic                    req_store_i,
  output cluster_metadata_t       meta_o,
  output logic [AxiAddrWidth-1:0] ax_addr_o,
  output logic [7:0]              ax_len_o,
  output logic [2:0]              ax_size_o,
  output logic [1:0]              ax_burst_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned AxiBeatBytes = AxiDataWidth / 8;
  localparam int unsigned BeatShift    = $clog2(AxiBeatBytes);
  localparam int unsigned BeatsWidth   = VlWidth + 4;
  localparam int unsigned SumWidth     = BeatsWidth + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [BeatsWidth-1:0]   beats_q, beats_d;
  logic                    store_q, store_d;
  cluster_metadata_t       meta_q, meta_d;

  logic [SumWidth-1:0]     total_bytes;
  logic [BeatsWidth-1:0]   beats_init;
  logic [8:0]              cur_len;
  logic [AxiAddrWidth-1:0] next_addr;
  logic                    issue;
  logic                    ax_hs;

  align_burst_calc #(
    .AxiAddrWidth (AxiAddrWidth),
    .BeatsWidth   (BeatsWidth),
    .BeatShift    (BeatShift),
    .MaxBurstLen  (MaxBurstLen)
  ) u_calc (
    .cur_addr_i   (addr_q),
    .beats_left_i (beats_q),
    .cur_len_o    (cur_len),
    .next_addr_o  (next_addr)
  );

  // Start offset within the beat plus payload bytes, rounded up to whole beats.
  always_comb begin
    total_bytes = SumWidth'(req_addr_i[BeatShift-1:0])
                + (SumWidth'(req_vl_i) << req_vew_i)
                + SumWidth'(AxiBeatBytes - 1);
    beats_init  = BeatsWidth'(total_bytes >> BeatShift);
  end

  always_comb begin
    issue = (state_q == StIssue);
    ax_hs = issue & (store_q ? aw_ready_i : ar_ready_i);

    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    store_d = store_q;
    meta_d  = meta_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d     = req_addr_i;
          beats_d    = beats_init;
          store_d    = req_store_i;
          meta_d.vl  = vlen_cluster_t'(req_vl_i);
          meta_d.vew = req_vew_i;
          state_d    = (req_vl_i == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (ax_hs) begin
          addr_d  = next_addr;
          beats_d = beats_q - BeatsWidth'(cur_len);
          if (beats_q == BeatsWidth'(cur_len)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      beats_q <= '0;
      store_q <= 1'b0;
      meta_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      store_q <= store_d;
      meta_q  <= meta_d;
    end
  end

  always_comb begin
    req_ready_o = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
    ar_valid_o  = issue & ~store_q;
    aw_valid_o  = issue & store_q;
    meta_o      = meta_q;
    ax_addr_o   = addr_q;
    // beats_q is 0 outside ISSUE, so gate the length to keep it at 0 there.
    ax_len_o    = issue ? 8'(cur_len - 9'd1) : 8'd0;
    ax_size_o   = 3'(BeatShift);
    ax_burst_o  = AxiBurstIncr;
  end

endmodule

// File: tb/tb_align_req_sequencer.sv
// Self-checking bench for align_req_sequencer: descriptor table with a burst scoreboard,
// plus hand-written stall and mid-descriptor reset sequences.
module tb_align_req_sequencer;
  import ara_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_addr;
  logic [15:0]       req_vl;
  vew_e              req_vew;
  logic              req_store;
  cluster_metadata_t meta;
  logic [63:0]       ax_addr;
  logic [7:0]        ax_len;
  logic [2:0]        ax_size;
  logic [1:0]        ax_burst;
  logic              ar_valid, ar_ready, aw_valid, aw_ready;
  logic              busy, done;

  align_req_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_vl_i    (req_vl),
    .req_vew_i   (req_vew),
    .req_store_i (req_store),
    .meta_o      (meta),
    .ax_addr_o   (ax_addr),
    .ax_len_o    (ax_len),
    .ax_size_o   (ax_size),
    .ax_burst_o  (ax_burst),
    .ar_valid_o  (ar_valid),
    .ar_ready_i  (ar_ready),
    .aw_valid_o  (aw_valid),
    .aw_ready_i  (aw_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        store;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [15:0] vl;
    logic [1:0]  vew;
  } exp_t;

  typedef struct packed {
    logic            store;
    logic [63:0]     addr;
    logic [15:0]     vl;
    logic [1:0]      vew;
    int              n;
    logic [3:0][63:0] baddr;
    logic [3:0][7:0]  blen;
  } vec_t;

  localparam int NumVecs = 7;

  vec_t vecs[NumVecs];
  exp_t sb[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Burst monitor: every AR/AW handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ar_valid && aw_valid) check("ar_aw_both_valid", 1, 0);
      if ((ar_valid && ar_ready) || (aw_valid && aw_ready)) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_burst", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("burst_addr", ax_addr, e.addr);
          check("burst_len", 64'(ax_len), 64'(e.len));
          check("burst_is_aw", 64'(aw_valid), 64'(e.store));
          check("burst_meta_vl", 64'(meta.vl), 64'(e.vl));
          check("burst_meta_vew", 64'(meta.vew), 64'(e.vew));
          check("burst_size", 64'(ax_size), 64'd6);
          check("burst_type", 64'(ax_burst), 64'd1);
        end
      end
    end
  end

  task automatic set_vec(input int k, input logic st, input logic [63:0] a, input logic [15:0] vl,
                         input logic [1:0] vew, input int n,
                         input logic [63:0] a0, input logic [7:0] l0,
                         input logic [63:0] a1, input logic [7:0] l1,
                         input logic [63:0] a2, input logic [7:0] l2,
                         input logic [63:0] a3, input logic [7:0] l3);
    vecs[k].store = st;  vecs[k].addr = a;  vecs[k].vl = vl;  vecs[k].vew = vew;
    vecs[k].n = n;
    vecs[k].baddr[0] = a0; vecs[k].blen[0] = l0;
    vecs[k].baddr[1] = a1; vecs[k].blen[1] = l1;
    vecs[k].baddr[2] = a2; vecs[k].blen[2] = l2;
    vecs[k].baddr[3] = a3; vecs[k].blen[3] = l3;
  endtask

  task automatic drive_desc(input int k);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = vecs[k].addr;
    req_vl    = vecs[k].vl;
    req_vew   = vew_e'(vecs[k].vew);
    req_store = vecs[k].store;
    for (int i = 0; i < vecs[k].n; i++)
      sb.push_back('{store: vecs[k].store, addr: vecs[k].baddr[i], len: vecs[k].blen[i],
                     vl: vecs[k].vl, vew: vecs[k].vew});
    hs_cyc.delete();
  endtask

  // Apply one table entry under full ready and check bursts, latency and done timing.
  task automatic run_vec(input int k);
    int acc;
    int done_cyc;
    bit got;
    int n;
    n = vecs[k].n;
    drive_desc(k);
    @(negedge clk);
    check($sformatf("v%0d_req_ready", k), 64'(req_ready), 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 1'b0;
    done_cyc = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check($sformatf("v%0d_done_seen", k), 64'(got), 64'd1);
    check($sformatf("v%0d_bursts_left", k), 64'(sb.size()), 64'd0);
    check($sformatf("v%0d_burst_count", k), 64'(hs_cyc.size()), 64'(n));
    if (n == 0) begin
      check($sformatf("v%0d_done_cycle", k), 64'(done_cyc), 64'(acc + 1));
    end else if (hs_cyc.size() == n) begin
      check($sformatf("v%0d_first_latency", k), 64'(hs_cyc[0]), 64'(acc + 1));
      for (int i = 1; i < n; i++)
        check($sformatf("v%0d_b2b_%0d", k, i), 64'(hs_cyc[i]), 64'(hs_cyc[i-1] + 1));
      check($sformatf("v%0d_done_cycle", k), 64'(done_cyc), 64'(hs_cyc[n-1] + 1));
    end
    check($sformatf("v%0d_meta_vl_hold", k), 64'(meta.vl), 64'(vecs[k].vl));
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", k), 64'(done), 64'd0);
    check($sformatf("v%0d_idle_ready", k), 64'(req_ready), 64'd1);
    check($sformatf("v%0d_idle_busy", k), 64'(busy), 64'd0);
    check($sformatf("v%0d_meta_vew_hold", k), 64'(meta.vew), 64'(vecs[k].vew));
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0;  req_valid = 1'b0;  req_addr = '0;  req_vl = '0;
    req_vew = EW8; req_store = 1'b0;  ar_ready = 1'b1; aw_ready = 1'b1;

    //        k  st  addr     vl    vew n  bursts (addr, len)
    set_vec(0, 0, 64'h1000,  64, 2'd3, 1, 64'h1000,  7, 0, 0, 0, 0, 0, 0);
    set_vec(1, 0, 64'h1004,  32, 2'd2, 1, 64'h1004,  2, 0, 0, 0, 0, 0, 0);
    set_vec(2, 0, 64'h0FC0, 128, 2'd3, 2, 64'h0FC0,  0, 64'h1000, 14, 0, 0, 0, 0);
    set_vec(3, 0, 64'h2000, 512, 2'd3, 4, 64'h2000, 15, 64'h2400, 15, 64'h2800, 15,
            64'h2C00, 15);
    set_vec(4, 0, 64'h5000,   0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_vec(5, 1, 64'h4FF8,   4, 2'd3, 2, 64'h4FF8,  0, 64'h5000,  0, 0, 0, 0, 0);
    set_vec(6, 1, 64'h3000,  16, 2'd0, 1, 64'h3000,  0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ar_valid", 64'(ar_valid), 64'd0);
    check("rst_aw_valid", 64'(aw_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_meta", 64'(meta), 64'd0);
    check("rst_ax_addr", ax_addr, 64'd0);
    check("rst_ax_len", 64'(ax_len), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < NumVecs; k++) run_vec(k);

    // Store with AW stalled: valid, fields and metadata must hold, AR stays idle.
    aw_ready = 1'b0;
    drive_desc(6);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_aw_valid", 64'(aw_valid), 64'd1);
      check("stall_ar_valid", 64'(ar_valid), 64'd0);
      check("stall_addr", ax_addr, 64'h3000);
      check("stall_len", 64'(ax_len), 64'd0);
      check("stall_meta", 64'(meta), {46'd0, 16'd16, 2'd0});
    end
    @(posedge clk); #1;
    aw_ready = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      check("stall_done_seen", 64'(got), 64'd1);
      check("stall_bursts_left", 64'(sb.size()), 64'd0);
      check("stall_burst_count", 64'(hs_cyc.size()), 64'd1);
    end
    sb.delete();

    // Reset in the middle of the 4-burst load after two bursts have gone out.
    drive_desc(3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("mid_pre_ar_valid", 64'(ar_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ar_valid", 64'(ar_valid), 64'd0);
    check("mid_rst_aw_valid", 64'(aw_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_bursts_done", 64'(hs_cyc.size()), 64'd2);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
